// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
//   rx_data_o  - received byte, stable while rx_valid_o is high
//   rx_valid_o - byte available, held until accepted
//   rx_ready_i - consumer ready; transfer on rx_valid_o && rx_ready_i
//   frame_err_o - one-cycle pulse, stop bit sampled low
//   overrun_o  - one-cycle pulse, new byte dropped because the last one was unaccepted
// Signal suffixes are from the receiver's point of view (master modport).
interface uart_rx_if #(
    parameter int unsigned datawidth_p = 8
);
    logic [datawidth_p-1:0] rx_data_o;
    logic                   rx_valid_o;
    logic                   rx_ready_i;
    logic                   frame_err_o;
    logic                   overrun_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output frame_err_o,
        output overrun_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  frame_err_o,
        input  overrun_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It deserialises the asynchronous RX line
// (LSB first) and presents each byte on a valid/ready handshake. It also
// flags framing errors and overruns.
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   rx_serial_i - asynchronous serial line, idle high
//   rx_if       - byte handshake and error pulses (uart_rx_if.master)
module uart_rx #(
    parameter int unsigned datawidth_p   = 8,
    parameter int unsigned clk_per_bit_p = 868
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      rx_serial_i,
    uart_rx_if.master rx_if
);
    localparam int unsigned CntW = $clog2(clk_per_bit_p);
    localparam int unsigned IdxW = $clog2(datawidth_p + 1);

    localparam logic [CntW-1:0] HalfLast = CntW'(clk_per_bit_p / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(clk_per_bit_p - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(datawidth_p - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q;
    logic                   sync1_q, sync2_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdxW-1:0]        idx_q;
    logic [datawidth_p-1:0] shift_q, shift_d;
    logic [datawidth_p-1:0] data_q;
    logic                   valid_q, frame_err_q, overrun_q;
    logic                   rx_s;

    assign rx_s = sync2_q;
    // LSB arrives first, so each new bit enters at the MSB and shifts down.
    assign shift_d = {rx_s, shift_q[datawidth_p-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx_serial_i;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Accept clears valid. A byte completing in the same cycle
            // reasserts it below, because the later assignment wins.
            if (valid_q && rx_if.rx_ready_i) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= StData;
                            idx_q   <= '0;
                        end else begin
                            state_q <= StIdle;  // glitch, not a start bit
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        idx_q   <= idx_q + IdxW'(1);
                        if (idx_q == IdxLast) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                            if (!valid_q || rx_if.rx_ready_i) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    // A held-low line must go high again before any new start bit.
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_if.rx_data_o   = data_q;
    assign rx_if.rx_valid_o  = valid_q;
    assign rx_if.frame_err_o = frame_err_q;
    assign rx_if.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with clk_per_bit_p=16 and datawidth_p=8.
// A negedge monitor counts valid cycles, handshakes and error pulses.
// The single initial block drives frames and checks the expected values.
module tb_uart_rx;
    localparam int unsigned CPB = 16;

    logic clk;
    logic rst_n;
    logic serial;

    uart_rx_if #(.datawidth_p(8)) rx_if ();

    uart_rx #(
        .datawidth_p  (8),
        .clk_per_bit_p(CPB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_serial_i(serial),
        .rx_if      (rx_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    int       cyc       = 0;
    int       start_cyc = 0;
    int       rise_cyc  = 0;
    logic [7:0] rise_data = '0;
    logic     vprev     = 1'b0;
    int       vcnt      = 0;
    int       hs_cnt    = 0;
    int       fe_cnt    = 0;
    int       ov_cnt    = 0;
    int       both_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.rx_valid_o && !vprev) begin
            rise_cyc  <= cyc;
            rise_data <= rx_if.rx_data_o;
        end
        vprev <= rx_if.rx_valid_o;
        if (rx_if.rx_valid_o) vcnt <= vcnt + 1;
        if (rx_if.rx_valid_o && rx_if.rx_ready_i) hs_cnt <= hs_cnt + 1;
        if (rx_if.frame_err_o) fe_cnt <= fe_cnt + 1;
        if (rx_if.overrun_o) ov_cnt <= ov_cnt + 1;
        if (rx_if.frame_err_o && rx_if.overrun_o) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bit period: the line changes just after a rising edge and holds for CPB edges.
    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 serial = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    // Full frame. If pulse_ready is set, rx_ready_i is high only for the
    // stop-sample edge (edge 154 after the first low sample).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pulse_ready);
        @(posedge clk);
        #1 serial = 1'b0;
        start_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (!pulse_ready) begin
            drive_bit(stop);
        end else begin
            @(posedge clk);
            #1 serial = stop;
            repeat (10) @(posedge clk);
            #1 rx_if.rx_ready_i = 1'b1;
            @(posedge clk);
            #1 rx_if.rx_ready_i = 1'b0;
            repeat (4) @(posedge clk);
        end
    endtask

    int v0, h0, f0, o0;

    initial begin
        serial = 1'b1;
        rx_if.rx_ready_i = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("reset_data", 32'(rx_if.rx_data_o), 32'h0);
        chk("reset_valid", 32'(rx_if.rx_valid_o), 32'h0);
        chk("reset_ferr", 32'(rx_if.frame_err_o), 32'h0);
        chk("reset_ovr", 32'(rx_if.overrun_o), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 1: single byte, ready high. Rise at E154, so cyc has advanced by 155.
        v0 = vcnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_latency", 32'(rise_cyc - start_cyc), 32'd155);
        chk("t1_rise_data", 32'(rise_data), 32'hA5);
        chk("t1_data", 32'(rx_if.rx_data_o), 32'hA5);
        chk("t1_valid_cycles", 32'(vcnt - v0), 32'd1);
        chk("t1_no_err", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

        // 2: overrun with ready low, then drain.
        rx_if.rx_ready_i = 1'b0;
        o0 = ov_cnt; h0 = hs_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        #1;
        chk("t2_valid1", 32'(rx_if.rx_valid_o), 32'h1);
        chk("t2_data1", 32'(rx_if.rx_data_o), 32'h3C);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_data_held", 32'(rx_if.rx_data_o), 32'h3C);
        chk("t2_valid_held", 32'(rx_if.rx_valid_o), 32'h1);
        chk("t2_overrun", 32'(ov_cnt - o0), 32'd1);
        rx_if.rx_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_valid_drained", 32'(rx_if.rx_valid_o), 32'h0);
        chk("t2_handshakes", 32'(hs_cnt - h0), 32'd1);

        // 3: 4-cycle glitch is a false start, then a real byte.
        v0 = vcnt; f0 = fe_cnt;
        @(posedge clk);
        #1 serial = 1'b0;
        repeat (4) @(posedge clk);
        #1 serial = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t3_no_valid", 32'(vcnt - v0), 32'd0);
        chk("t3_no_ferr", 32'(fe_cnt - f0), 32'd0);
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_data", 32'(rx_if.rx_data_o), 32'h55);
        chk("t3_valid_cycles", 32'(vcnt - v0), 32'd1);

        // 4: framing error followed by a held-low break, then recovery.
        v0 = vcnt; f0 = fe_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1 serial = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_ferr_once", 32'(fe_cnt - f0), 32'd1);
        chk("t4_no_valid", 32'(vcnt - v0), 32'd0);
        chk("t4_data_kept", 32'(rx_if.rx_data_o), 32'h55);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_data", 32'(rx_if.rx_data_o), 32'h0F);
        chk("t4_valid_cycles", 32'(vcnt - v0), 32'd1);
        chk("t4_ferr_total", 32'(fe_cnt - f0), 32'd1);

        // 5: asynchronous reset during data bit 3 of 0xC3.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge clk);
        #1 serial = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_pre_data", 32'(rx_if.rx_data_o), 32'h0F);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_data", 32'(rx_if.rx_data_o), 32'h0);
        chk("t5_rst_valid", 32'(rx_if.rx_valid_o), 32'h0);
        chk("t5_rst_ferr", 32'(rx_if.frame_err_o), 32'h0);
        chk("t5_rst_ovr", 32'(rx_if.overrun_o), 32'h0);
        serial = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        v0 = vcnt;
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_data", 32'(rx_if.rx_data_o), 32'h7E);
        chk("t5_valid_cycles", 32'(vcnt - v0), 32'd1);

        // 6: accept and load on the same edge.
        rx_if.rx_ready_i = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0);
        #1;
        chk("t6_data1", 32'(rx_if.rx_data_o), 32'h01);
        o0 = ov_cnt; h0 = hs_cnt;
        send_frame(8'h02, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_valid_kept", 32'(rx_if.rx_valid_o), 32'h1);
        chk("t6_data2", 32'(rx_if.rx_data_o), 32'h02);
        chk("t6_no_overrun", 32'(ov_cnt - o0), 32'd0);
        chk("t6_handshakes", 32'(hs_cnt - h0), 32'd1);
        rx_if.rx_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_drained", 32'(rx_if.rx_valid_o), 32'h0);
        chk("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
